// File: rtl/hcount_line_timer.sv
// hcount_line_timer
// Horizontal timing stage of the VGA controller. Counts pixel positions
// across one scan line and walks ACTIVE -> FRONT -> SYNC -> BACK. It drives
// Hsync and emits a one-Clock LineEnd pulse, which is the count enable for
// the vertical counter.
//
// Optional feature macro: HCOUNT_PIXDIV_EN
//   defined   : PixEn is a registered divide-by-2 toggle. Everything
//               advances only when PixEn = 1.
//   undefined : PixEn is tied to 1. The line advances every Clock and no
//               toggle register exists.
//
// state     | meaning
// ----------+------------------------------------------------
// ST_ACTIVE | visible pixels, Q in [0, H_ACTIVE-1]
// ST_FRONT  | front porch, Q in [H_ACTIVE, H_ACTIVE+H_FRONT-1]
// ST_SYNC   | sync pulse, Hsync = HSYNC_POL
// ST_BACK   | back porch, ends at Q = H_TOTAL-1
module hcount_line_timer #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter bit HSYNC_POL = 1'b0
) (
   input  logic       Clock,
   input  logic       Clear,
   output logic [9:0] Q,
   output logic       Active,
   output logic       Front,
   output logic       Sync,
   output logic       Back,
   output logic       Hsync,
   output logic       LineEnd,
   output logic       PixEn
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

   // Bad timing parameters must stop elaboration rather than wrap silently.
   if (H_TOTAL > 1024 || H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1) begin : g_bad_params
      $error("hcount_line_timer: H_TOTAL must be <= 1024 and every region >= 1");
   end

   // Last pixel of each region; the state changes when Q steps past it.
   localparam logic [9:0] A_LAST = 10'(H_ACTIVE - 1);
   localparam logic [9:0] F_LAST = 10'(H_ACTIVE + H_FRONT - 1);
   localparam logic [9:0] S_LAST = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] T_LAST = 10'(H_TOTAL - 1);

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_FRONT  = 2'd1,
      ST_SYNC   = 2'd2,
      ST_BACK   = 2'd3
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [9:0] q_next;
   logic       active_next;
   logic       front_next;
   logic       sync_next;
   logic       back_next;
   logic       hsync_next;

`ifdef HCOUNT_PIXDIV_EN
   // Divide-by-2 pixel enable. It starts at 0 after Clear, so the first
   // count happens on the second edge after release.
   always_ff @(posedge Clock) begin
      if (Clear) PixEn <= 1'b0;
      else       PixEn <= ~PixEn;
   end
`else
   assign PixEn = 1'b1;
`endif

   // Next Q, next state and the decoded outputs for that state. The flags
   // come from the next state, so once registered they always match Q.
   always_comb begin
      state_next = state;
      q_next     = Q;
      if (PixEn) begin
         q_next = (Q == T_LAST) ? 10'd0 : Q + 10'd1;
         unique case (state)
            ST_ACTIVE: if (Q == A_LAST) state_next = ST_FRONT;
            ST_FRONT:  if (Q == F_LAST) state_next = ST_SYNC;
            ST_SYNC:   if (Q == S_LAST) state_next = ST_BACK;
            ST_BACK:   if (Q == T_LAST) state_next = ST_ACTIVE;
            default:   state_next = ST_ACTIVE;
         endcase
      end
      active_next = (state_next == ST_ACTIVE);
      front_next  = (state_next == ST_FRONT);
      sync_next   = (state_next == ST_SYNC);
      back_next   = (state_next == ST_BACK);
      hsync_next  = sync_next ? HSYNC_POL : ~HSYNC_POL;
   end

   // State, counter, one-hot flags and Hsync all load on the same edge.
   // Clear takes priority over everything else.
   always_ff @(posedge Clock) begin
      if (Clear) begin
         state  <= ST_ACTIVE;
         Q      <= 10'd0;
         Active <= 1'b1;
         Front  <= 1'b0;
         Sync   <= 1'b0;
         Back   <= 1'b0;
         Hsync  <= ~HSYNC_POL;
      end else begin
         state  <= state_next;
         Q      <= q_next;
         Active <= active_next;
         Front  <= front_next;
         Sync   <= sync_next;
         Back   <= back_next;
         Hsync  <= hsync_next;
      end
   end

   // LineEnd is decoded only from registers, so it cannot glitch. Q reads 0
   // after Clear, so no pulse can follow a reset.
   assign LineEnd = (Q == T_LAST) && PixEn;

endmodule

// File: doc/hcount_line_timer.md
# hcount_line_timer

Horizontal timing stage of the VGA controller, directly upstream of the vertical counter. It counts pixel positions across one scan line, tracks the four horizontal regions (active, front porch, sync, back porch) with an explicit state machine, and drives the horizontal sync pin. It emits a one-cycle `LineEnd` pulse that the vertical counter uses as its count enable, so both counters share the single `Clock`.

## Interface
Parameters:
- `H_ACTIVE`, default 640: visible pixels per line.
- `H_FRONT`, default 16: front-porch pixels.
- `H_SYNC`, default 96: sync-pulse pixels.
- `H_BACK`, default 48: back-porch pixels.
- `HSYNC_POL`, default 0: active level of `Hsync` (0 = active-low).
- `H_TOTAL` is derived, not settable: `H_ACTIVE+H_FRONT+H_SYNC+H_BACK`, default 800.

Ports:
- `Clock`  in  1: single clock. Every register updates on the rising edge.
- `Clear`  in  1: reset, synchronous and active-high. It has priority over all other activity.
- `Q`  out  10: horizontal pixel count, 0 … H_TOTAL-1.
- `Active`  out  1: high while in the ACTIVE region.
- `Front`  out  1: high while in the FRONT region.
- `Sync`  out  1: high while in the SYNC region.
- `Back`  out  1: high while in the BACK region.
- `Hsync`  out  1: horizontal sync pin. It equals `HSYNC_POL` in the SYNC region and `~HSYNC_POL` elsewhere.
- `LineEnd`  out  1: one-Clock pulse on the last pixel of each line. It is the count enable for the vertical counter.
- `PixEn`  out  1: pixel advance enable, exported so downstream stages stay aligned.

## Operation
- The state machine has four states: ACTIVE → FRONT → SYNC → BACK → ACTIVE.
- Each transition happens on the advance edge where `Q` crosses a region boundary:
  - `Q`: H_ACTIVE-1 → H_ACTIVE enters FRONT.
  - `Q`: H_ACTIVE+H_FRONT-1 → next enters SYNC.
  - `Q`: H_ACTIVE+H_FRONT+H_SYNC-1 → next enters BACK.
  - `Q`: H_TOTAL-1 → 0 enters ACTIVE.
- The advance condition is `PixEn`=1. Without the configuration macro, `PixEn` is always 1.
- On an advance edge, `Q` increments. At H_TOTAL-1 it wraps to 0. Without advance, `Q` holds.
- The region flags are one-hot and registered, and always consistent with `Q` in the same cycle.
- `Hsync` is registered and updated on the same edge as the state change.
- `LineEnd` = (`Q`==H_TOTAL-1) && `PixEn`. It is decoded from registers only, so it is glitch-free. The vertical counter increments on the same edge that wraps `Q` to 0.
- Width rules:
  - `Q` is 10 bits.
  - H_TOTAL ≤ 1024 and every region ≥ 1 are elaboration-time checks. A violation stops elaboration with an error.
- Reset values (applied on the edge where `Clear`=1):
  - `Q`=0, state ACTIVE, `Active`=1.
  - `Front`=`Sync`=`Back`=0.
  - `Hsync`=`~HSYNC_POL`.
  - `LineEnd`=0.
  - `PixEn`=0 with the macro, 1 without.
- Clear mid-line (any state, any `Q`): the next edge returns all outputs to their reset values. No partial-line pulse is emitted.
- Clear on the `LineEnd` cycle: reset wins. `Q`=0 on the next edge, and `LineEnd` is 0 from that edge on.

## Timing
- Latency from `Clear` deasserted to the first increment:
  - Without the macro: one Clock. The first edge with `Clear`=0 moves `Q` 0 → 1.
  - With the macro: two Clocks, because `PixEn` is 0 on the first edge after Clear release.
- Line period: H_TOTAL Clocks without the macro, 2·H_TOTAL Clocks with it.
- `LineEnd` is high for exactly one Clock per line, and low in all other cycles.
- Sync pulse: exactly H_SYNC advance periods.
- The region flags and `Hsync` change only on advance edges, or on Clear.

## Configuration
- Macro `HCOUNT_PIXDIV_EN`.
- Defined:
  - `PixEn` is a registered toggle giving divide-by-2 (for example 50 MHz `Clock` → 25 MHz pixel rate).
  - Reset value 0; it toggles every Clock after Clear releases.
  - Counting, state changes and `LineEnd` occur only when `PixEn`=1.
- Undefined:
  - `PixEn` is constant 1.
  - The block advances every Clock.
  - No toggle register is synthesized.

## Test plan
- **Reset:** hold `Clear`=1 for 3 Clocks with `Q` mid-count → `Q`=0, `Active`=1, other flags 0, `Hsync`=1, `LineEnd`=0.
- **Full line, default params, macro undefined:**
  - Release `Clear`, run 800 Clocks.
  - `Active`→`Front` when `Q` goes 639→640.
  - `Hsync` falls when `Q` goes 655→656 and rises when `Q` goes 751→752.
  - `LineEnd`=1 only while `Q`=799; `Q` wraps to 0 on the next edge.
- **Two lines:** run 1600 Clocks → exactly two `LineEnd` pulses, 800 Clocks apart. The vertical counter model, fed by `LineEnd`, reads 2.
- **Clear mid-line:** assert `Clear` for 1 Clock at `Q`=700 (state SYNC) → next edge gives `Q`=0, `Active`=1, `Hsync`=1, and no `LineEnd` pulse.
- **Small params:** H_ACTIVE=4, H_FRONT=1, H_SYNC=2, H_BACK=1 → 8-Clock period; `Sync`=1 only at `Q`=5 and 6; `LineEnd` at `Q`=7.
- **`HCOUNT_PIXDIV_EN` defined, default params:**
  - `PixEn` alternates 0,1 from Clear release.
  - `Q` holds for 2 Clocks per value.
  - `LineEnd` pulses once every 1600 Clocks, for 1 Clock.
